// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: accepts fade commands and ramps a registered PWM duty value
// toward a target. The duty changes by a fixed step once per PWM period and
// then holds for a programmable number of periods. A completion pulse marks
// the end of a fade. An abort leaves the duty value where it is.
module pwm_fade_ctrl #(
  parameter int PD_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PD_CNT-1:0] cmd_target,
  input  logic [PD_CNT-1:0] cmd_step,
  input  logic [PD_CNT-1:0] cmd_hold,
  input  logic              abort,
  output logic [PD_CNT-1:0] duty_cnt,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [PD_CNT-1:0] ONE = {{(PD_CNT-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [PD_CNT-1:0]   presc_q, presc_d;
  logic [PD_CNT-1:0]   duty_q;
  logic [PD_CNT-1:0]   target_q, step_q, hold_q;
  logic [PD_CNT-1:0]   hold_cnt_q;
  logic                ready_q, busy_q, done_q;

  logic                tick;
  logic                ramp_up;
  logic                ramp_last;
  logic [PD_CNT:0]     diff_x;
  logic [PD_CNT-1:0]   ramp_d;

  // One tick per PWM period: the last count of the prescaler.
  assign tick    = &presc_q;
  assign presc_d = presc_q + ONE;

  // Free-running prescaler that sets the PWM period.
  always_ff @(posedge clk) begin
    // NOTE: all state in clocked blocks uses non-blocking assignment so every
    // register samples the values from before the edge, regardless of order.
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Next ramp value: distance to target is taken one bit wider so the
  // "close enough" decision can never be fooled by wrap-around. When the
  // remaining distance exceeds the step, moving by the step stays strictly
  // between duty and target, so the narrow add/subtract cannot overflow.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    ramp_up   = 1'b0;
    diff_x    = '0;
    ramp_last = 1'b0;
    ramp_d    = duty_q;
    if ({1'b0, target_q} >= {1'b0, duty_q}) begin
      ramp_up = 1'b1;
      diff_x  = {1'b0, target_q} - {1'b0, duty_q};
    end else begin
      diff_x  = {1'b0, duty_q} - {1'b0, target_q};
    end
    ramp_last = (diff_x <= {1'b0, step_q});
    if (ramp_last) begin
      ramp_d = target_q;
    end else if (ramp_up) begin
      ramp_d = duty_q + step_q;
    end else begin
      ramp_d = duty_q - step_q;
    end
  end

  // Fade sequencer: command acceptance, ramping, holding, abort and the
  // registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the latched command fields are cleared too; they are only a few
      // registers and a known value keeps the ramp logic quiet after reset.
      state_q    <= IDLE;
      duty_q     <= '0;
      target_q   <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && ready_q) begin
            target_q <= cmd_target;
            step_q   <= (cmd_step == '0) ? ONE : cmd_step;
            hold_q   <= cmd_hold;
            state_q  <= RAMP;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        RAMP: begin
          if (abort) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tick) begin
            duty_q <= ramp_d;
            if (ramp_last) begin
              state_q    <= HOLD;
              hold_cnt_q <= hold_q;
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (hold_cnt_q == '0) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q - ONE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign duty_cnt  = duty_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl with PD_CNT=4 (one tick per 16 clocks). A model
// plans each fade as a list of duty values and a count of hold periods. The
// model is compared against the DUT on every cycle. Directed scenarios add
// literal expectations at each tick.
module tb_pwm_fade_ctrl;

  localparam int PD     = 4;
  localparam int PERIOD = 16;
  localparam int P_IDLE = 0;
  localparam int P_RAMP = 1;
  localparam int P_HOLD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [PD-1:0] cmd_target;
  logic [PD-1:0] cmd_step;
  logic [PD-1:0] cmd_hold;
  logic          abort;
  logic [PD-1:0] duty_cnt;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  pwm_fade_ctrl #(.PD_CNT(PD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_hold   (cmd_hold),
    .abort      (abort),
    .duty_cnt   (duty_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_presc, m_duty, m_phase, m_hold_left, m_hold_val;
  bit m_ready, m_busy, m_done, m_valid;
  int m_queue[$];

  // The whole duty sequence of one fade, one entry per tick.
  function automatic void plan_ramp(input int from, input int to, input int step);
    int d;
    d = from;
    m_queue.delete();
    do begin
      if (((to > d) ? to - d : d - to) <= step) d = to;
      else if (to > d) d = d + step;
      else d = d - step;
      m_queue.push_back(d);
    end while (d != to);
  endfunction

  initial begin
    bit tick;
    m_presc = 0; m_duty = 0; m_phase = P_IDLE; m_hold_left = 0; m_hold_val = 0;
    m_ready = 0; m_busy = 0; m_done = 0; m_valid = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_presc = 0; m_phase = P_IDLE; m_duty = 0; m_done = 0; m_ready = 0;
        m_queue.delete();
      end else begin
        tick    = (m_presc == PERIOD - 1);
        m_presc = (m_presc + 1) % PERIOD;
        m_done  = 0;
        case (m_phase)
          P_IDLE: if (cmd_valid && m_ready) begin
            plan_ramp(m_duty, int'(cmd_target), (cmd_step == 0) ? 1 : int'(cmd_step));
            m_hold_val = int'(cmd_hold);
            m_phase    = P_RAMP;
          end
          P_RAMP: if (abort) m_phase = P_IDLE;
            else if (tick) begin
              m_duty = m_queue.pop_front();
              if (m_queue.size() == 0) begin
                m_phase     = P_HOLD;
                m_hold_left = m_hold_val + 1;
              end
            end
          P_HOLD: if (abort) m_phase = P_IDLE;
            else if (tick) begin
              m_hold_left--;
              if (m_hold_left == 0) begin
                m_phase = P_IDLE;
                m_done  = 1;
              end
            end
          default: m_phase = P_IDLE;
        endcase
        m_ready = (m_phase == P_IDLE);
      end
      m_busy  = (m_phase != P_IDLE);
      m_valid = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("cyc_duty",  int'(duty_cnt),  m_duty);
      check("cyc_busy",  int'(busy),      int'(m_busy));
      check("cyc_ready", int'(cmd_ready), int'(m_ready));
      check("cyc_done",  int'(done),      int'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Advance to the first cycle after the next tick edge (at least one cycle).
  task automatic next_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (m_presc != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tick_wait", m_presc, 0);
  endtask

  task automatic issue(input int t, input int s, input int h, input bit with_abort);
    cmd_target = t[PD-1:0];
    cmd_step   = s[PD-1:0];
    cmd_hold   = h[PD-1:0];
    cmd_valid  = 1'b1;
    abort      = with_abort;
    @(negedge clk);
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    check("accept_busy",  int'(busy),      1);
    check("accept_ready", int'(cmd_ready), 0);
  endtask

  task automatic ramp_expect(input string name, input int exp_q[$]);
    foreach (exp_q[i]) begin
      next_tick();
      check(name, int'(duty_cnt), exp_q[i]);
      check({name, "_busy"}, int'(busy), 1);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_target = '0; cmd_step = '0; cmd_hold = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_duty",  int'(duty_cnt),  0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(cmd_ready), 1);

    // Ramp up 0 -> 10, step 3, hold 2
    issue(10, 3, 2, 1'b0);
    ramp_expect("up_duty", '{3, 6, 9, 10});
    repeat (2) begin
      next_tick();
      check("up_hold_busy", int'(busy), 1);
      check("up_hold_done", int'(done), 0);
    end
    next_tick();
    check("up_done",  int'(done),      1);
    check("up_ready", int'(cmd_ready), 1);
    check("up_idle",  int'(busy),      0);
    check("up_final", int'(duty_cnt),  10);
    @(negedge clk);
    check("up_done_pulse", int'(done), 0);

    // Ramp down 10 -> 0, step 4, saturating at 0
    issue(0, 4, 0, 1'b0);
    ramp_expect("down_duty", '{6, 2, 0});
    next_tick();
    check("down_done", int'(done),     1);
    check("down_duty", int'(duty_cnt), 0);

    // Zero step treated as 1, zero hold
    issue(2, 0, 0, 1'b0);
    ramp_expect("zstep_duty", '{1, 2});
    next_tick();
    check("zstep_done", int'(done), 1);

    // Abort coincident with a tick at duty 6
    issue(10, 4, 0, 1'b0);
    ramp_expect("abort_duty", '{6});
    n = 0;
    while (m_presc != PERIOD - 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_duty_frozen", int'(duty_cnt),  6);
    check("abort_idle",        int'(busy),      0);
    check("abort_ready",       int'(cmd_ready), 1);
    check("abort_no_done",     int'(done),      0);
    repeat (2) begin
      next_tick();
      check("abort_stays", int'(duty_cnt), 6);
    end

    // Abort with cmd_valid in IDLE accepts; reset in HOLD abandons the fade
    issue(8, 2, 5, 1'b1);
    ramp_expect("rst_fade_duty", '{8});
    next_tick();
    check("rst_fade_hold", int'(busy), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_duty",  int'(duty_cnt),  0);
    check("midrst_busy",  int'(busy),      0);
    check("midrst_done",  int'(done),      0);
    check("midrst_ready", int'(cmd_ready), 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_ready_low", int'(cmd_ready), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", int'(cmd_ready), 1);

    // Command offered while busy is ignored
    issue(5, 2, 1, 1'b0);
    ramp_expect("busycmd_duty", '{2});
    cmd_target = 4'd15; cmd_step = 4'd7; cmd_hold = 4'd0; cmd_valid = 1'b1;
    repeat (8) @(negedge clk);
    cmd_valid = 1'b0;
    ramp_expect("busycmd_duty", '{4, 5});
    next_tick();
    check("busycmd_hold", int'(busy), 1);
    check("busycmd_hold_done", int'(done), 0);
    next_tick();
    check("busycmd_done", int'(done),     1);
    check("busycmd_duty_final", int'(duty_cnt), 5);

    // Target equal to current duty still ramps once, then holds
    issue(5, 1, 0, 1'b0);
    ramp_expect("same_duty", '{5});
    next_tick();
    check("same_done", int'(done), 1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter PD_CNT, default 8: width of the duty value, the prescaler and the hold counter; must match the driven PWM channel.
REQ-002 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1: fade command offered.
REQ-005 SHALL have port cmd_ready, output, 1: controller can accept a command.
REQ-006 SHALL have port cmd_target, input, PD_CNT: final duty value.
REQ-007 SHALL have port cmd_step, input, PD_CNT: duty change per PWM period.
REQ-008 SHALL have port cmd_hold, input, PD_CNT: PWM periods to hold at the target.
REQ-009 SHALL have port abort, input, 1: cancel the active fade.
REQ-010 SHALL have port duty_cnt, output, PD_CNT: registered duty value for the PWM channel.
REQ-011 SHALL have port busy, output, 1: a fade is active.
REQ-012 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-013 SHALL run a free-running PD_CNT-bit prescaler that increments every clock and wraps from all-ones to 0.
REQ-014 SHALL assert an internal tick in every cycle where the prescaler equals all-ones, giving one tick per 2^PD_CNT clocks.
REQ-015 SHALL change duty_cnt only on the clock edge that ends a tick cycle, so each new duty is valid from prescaler count 0.
REQ-016 SHALL implement exactly three states: IDLE, RAMP and HOLD.
REQ-017 SHALL drive cmd_ready=1 only in IDLE, and busy=1 only in RAMP or HOLD.
REQ-018 SHALL accept a command in IDLE on a cycle with cmd_valid=1, latch target, step and hold, and enter RAMP on the next cycle.
REQ-019 SHALL treat cmd_step=0 as a step of 1.
REQ-020 SHALL, in RAMP on each tick, set duty_cnt=target and enter HOLD when |target-duty_cnt| <= step.
REQ-021 SHALL, in RAMP on each tick otherwise, move duty_cnt toward target by exactly step.
REQ-022 SHALL compute ramp arithmetic at PD_CNT+1 bits, so duty_cnt never overshoots, wraps or underflows.
REQ-023 SHALL, for a command whose target equals the current duty_cnt, still pass through RAMP, with the first tick entering HOLD.
REQ-024 SHALL load a hold counter from the latched hold value on entry to HOLD.
REQ-025 SHALL, in HOLD on each tick, return to IDLE and pulse done for one cycle if the hold counter is 0, otherwise decrement it; HOLD therefore lasts hold+1 ticks.
REQ-026 SHALL, when abort=1 in RAMP or HOLD, enter IDLE on the next cycle with duty_cnt frozen and no done pulse.
REQ-027 SHALL give abort priority over a coincident tick update.
REQ-028 SHALL ignore abort in IDLE; abort and cmd_valid together in IDLE SHALL accept the command.
REQ-029 SHALL ignore cmd_valid outside IDLE and SHALL NOT alter the latched parameters while busy.

Reset
REQ-030 SHALL, on any clock edge with rst=0, force state=IDLE, prescaler=0, duty_cnt=0, hold counter=0, done=0 and busy=0.
REQ-031 SHALL hold cmd_ready=0 while rst=0 and set it to 1 in the first cycle after rst returns to 1.
REQ-032 SHALL, on reset during RAMP or HOLD, abandon the fade with no done pulse, with duty_cnt=0 on the next cycle.

Verification (PD_CNT=4, one tick per 16 clocks)
REQ-033 SHALL cover a ramp up: from duty 0, command target=10, step=3, hold=2 -> duty 3, 6, 9, 10 on ticks 1-4, HOLD on ticks 5-7, done pulse after tick 7, cmd_ready=1 on the next cycle.
REQ-034 SHALL cover a ramp down with saturation: from duty 10, command target=0, step=4 -> duty 6, 2, 0 with no wrap, and busy=1 throughout.
REQ-035 SHALL cover a zero step and zero hold: command target=2, step=0, hold=0 from duty 0 -> duty 1, 2, then done after the following tick.
REQ-036 SHALL cover an abort: abort=1 during RAMP at duty 6, coincident with a tick -> duty stays 6, IDLE next cycle, no done pulse.
REQ-037 SHALL cover mid-fade reset: rst=0 during HOLD -> duty_cnt=0, busy=0, done=0 and cmd_ready=0 until rst=1, then cmd_ready=1.
REQ-038 SHALL cover a busy command: cmd_valid=1 with a new target while busy -> the command is ignored and the original fade completes unchanged.
